// File: rtl/comp_mult_arb.sv
// comp_mult_arb: two-requester arbiter in front of a single shared complex
// multiplier. One transaction in flight at a time; round-robin on conflict.
// Operand and result words pass through untouched.
module comp_mult_arb #(
   parameter int DWIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sw_rst,
   input  logic [1:0]                   op_val,
   output logic [1:0]                   op_rdy,
   input  logic [2*4*DWIDTH-1:0]        op_data,
   output logic [1:0]                   res_val,
   input  logic [1:0]                   res_rdy,
   output logic [2*4*(DWIDTH+1)-1:0]    res_data,
   output logic                         m_op_val,
   input  logic                         m_op_rdy,
   output logic [4*DWIDTH-1:0]          m_op_data,
   input  logic                         m_res_val,
   output logic                         m_res_rdy,
   input  logic [4*(DWIDTH+1)-1:0]      m_res_data
);

   localparam int OW = 4*DWIDTH;
   localparam int RW = 4*(DWIDTH+1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, RET} state_t;

   state_t          state;
   logic            ptr;
   logic            id;
   logic            gnt;
   logic [OW-1:0]   op_sel;

   // Grant choice: the lone requester, or the one ptr favours when both ask
   always_comb begin
      gnt = 1'b0;
      if (op_val == 2'b11)
         gnt = ptr;
      else
         gnt = op_val[1];
   end

   // Ready only toward the granted requester, and only while idle
   always_comb begin
      op_rdy = 2'b00;
      if (state == IDLE && op_val[gnt])
         op_rdy[gnt] = 1'b1;
   end

   // Operand slice of the granted requester
   always_comb begin
      op_sel = gnt ? op_data[2*OW-1:OW] : op_data[OW-1:0];
   end

   // Transaction sequencer; every interface output is a register here
   always_ff @(posedge clk) begin
      if (!rst_n || sw_rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         id        <= 1'b0;
         m_op_data <= '0;
         m_op_val  <= 1'b0;
         m_res_rdy <= 1'b0;
         res_val   <= 2'b00;
         res_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_val[gnt]) begin
                  m_op_data <= op_sel;
                  id        <= gnt;
                  ptr       <= ~gnt;
                  m_op_val  <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (m_op_rdy) begin
                  m_op_val  <= 1'b0;
                  m_res_rdy <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (m_res_val) begin
                  m_res_rdy <= 1'b0;
                  // Only the owning slice is overwritten; the other keeps its last result
                  if (id)
                     res_data[2*RW-1:RW] <= m_res_data;
                  else
                     res_data[RW-1:0] <= m_res_data;
                  res_val   <= id ? 2'b10 : 2'b01;
                  state     <= RET;
               end
            end
            RET: begin
               if (res_rdy[id]) begin
                  res_val <= 2'b00;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comp_mult_arb.sv
// tb_comp_mult_arb: directed vectors with a queue scoreboard for grant order
// and delivered results, plus a behavioural shared multiplier.
module tb_comp_mult_arb;

   localparam int DW = 8;
   localparam int OW = 4*DW;
   localparam int RW = 4*(DW+1);

   logic              clk = 1'b0;
   logic              rst_n, sw_rst;
   logic [1:0]        op_val, op_rdy;
   logic [2*OW-1:0]   op_data;
   logic [1:0]        res_val, res_rdy;
   logic [2*RW-1:0]   res_data;
   logic              m_op_val, m_op_rdy;
   logic [OW-1:0]     m_op_data;
   logic              m_res_val, m_res_rdy;
   logic [RW-1:0]     m_res_data;

   int n_cmp = 0;
   int n_bad = 0;
   int n_grant = 0;
   int g;
   int mul_lat = 1;
   int mul_hold = 20;
   logic busy = 1'b0;
   logic [RW-1:0] mul_r;
   logic [RW:0]   exp_res_q[$];
   int            exp_gnt_q[$];
   logic [RW:0]   e;

   comp_mult_arb #(.DWIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
      .op_val(op_val), .op_rdy(op_rdy), .op_data(op_data),
      .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
      .m_op_val(m_op_val), .m_op_rdy(m_op_rdy), .m_op_data(m_op_data),
      .m_res_val(m_res_val), .m_res_rdy(m_res_rdy), .m_res_data(m_res_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [2*RW-1:0] act, input logic [2*RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] cmul(input logic [OW-1:0] op);
      logic signed [2*(DW+1)-1:0] x1, y1, x2, y2, re, im;
      x1 = {{(DW+2){op[4*DW-1]}}, op[4*DW-1:3*DW]};
      y1 = {{(DW+2){op[3*DW-1]}}, op[3*DW-1:2*DW]};
      x2 = {{(DW+2){op[2*DW-1]}}, op[2*DW-1:DW]};
      y2 = {{(DW+2){op[DW-1]}},   op[DW-1:0]};
      re = x1*x2 - y1*y2;
      im = x1*y2 + y1*x2;
      return {re, im};
   endfunction

   // Behavioural shared multiplier: answers mul_lat cycles after the operand handshake
   initial begin
      m_res_val  = 1'b0;
      m_res_data = '0;
      forever begin
         @(negedge clk);
         if (m_op_val && m_op_rdy) begin
            mul_r = cmul(m_op_data);
            repeat (mul_lat) @(posedge clk);
            #1;
            m_res_val  = 1'b1;
            m_res_data = mul_r;
            for (int k = 0; k < mul_hold; k++) begin
               @(negedge clk);
               if (m_res_rdy) break;
            end
            @(posedge clk);
            #1;
            m_res_val  = 1'b0;
            m_res_data = '0;
         end
      end
   end

   // Monitor: grant order, no-overlap and delivered results against the queues
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (op_val[i] && op_rdy[i]) begin
               n_grant++;
               chk("no_overlap", busy, 0);
               busy = 1'b1;
               if (exp_gnt_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL grant_id: unexpected grant to %0d, none expected", i);
               end else
                  chk("grant_id", i, exp_gnt_q.pop_front());
            end
            if (res_val[i] && res_rdy[i]) begin
               busy = 1'b0;
               if (exp_res_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL res_unexp: result on %0d, none expected", i);
               end else begin
                  e = exp_res_q.pop_front();
                  chk("res_id", i, e[RW]);
                  chk("res_data", (i == 1) ? res_data[2*RW-1:RW] : res_data[RW-1:0], e[RW-1:0]);
               end
            end
         end
         if (!rst_n || sw_rst) busy = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grants(input int target);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (n_grant >= target) break;
      end
      chk("grant_count", (n_grant >= target) ? 1 : 0, 1);
   endtask

   task automatic wait_res(input logic [1:0] m, input string nm);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (res_val == m) break;
      end
      chk(nm, res_val, m);
   endtask

   task automatic drain();
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (exp_res_q.size() == 0) break;
      end
      chk("drain", exp_res_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; sw_rst = 1'b0; op_val = 2'b00; op_data = '0;
      m_op_rdy = 1'b1; res_rdy = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_m_op_val", m_op_val, 0);
      chk("rst_m_res_rdy", m_res_rdy, 0);
      chk("rst_res_val", res_val, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_op_rdy", op_rdy, 0);

      // Single request from req0, minimum latency
      step();
      rst_n = 1'b1; op_val = 2'b01; op_data = {32'h0, 32'h03020104};
      exp_gnt_q.push_back(0);
      exp_res_q.push_back({1'b0, 18'h3FFFB, 18'h0000E});
      @(negedge clk);
      chk("t1_op_rdy", op_rdy, 2'b01);
      step();
      op_val = 2'b00;
      @(negedge clk);
      chk("t1_m_op_val", m_op_val, 1);
      chk("t1_m_op_data", m_op_data, 32'h03020104);
      chk("t1_res_val_c1", res_val, 0);
      @(negedge clk);
      chk("t1_m_res_rdy", m_res_rdy, 1);
      chk("t1_m_op_val_wait", m_op_val, 0);
      chk("t1_res_val_c2", res_val, 0);
      @(negedge clk);
      chk("t1_res_val_c3", res_val, 2'b01);
      chk("t1_res_data0", res_data[RW-1:0], {18'h3FFFB, 18'h0000E});
      @(negedge clk);
      chk("t1_back_idle", res_val, 0);

      // Both requesters held from reset: strict alternation
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; op_data = {32'h02030405, 32'h01010101}; op_val = 2'b11;
      for (int k = 0; k < 2; k++) begin
         exp_gnt_q.push_back(0);
         exp_gnt_q.push_back(1);
         exp_res_q.push_back({1'b0, 18'h00000, 18'h00002});
         exp_res_q.push_back({1'b1, 18'h3FFF9, 18'h00016});
      end
      g = n_grant;
      wait_grants(g + 4);
      step();
      op_val = 2'b00;
      drain();

      // Multiplier not ready for several cycles in SEND
      step();
      m_op_rdy = 1'b0; op_data = {32'h05000007, 32'hFFFF0100}; op_val = 2'b10;
      g = n_grant;
      exp_gnt_q.push_back(1);
      exp_res_q.push_back({1'b1, 18'h00000, 18'h00023});
      @(negedge clk);
      chk("t3_op_rdy", op_rdy, 2'b10);
      step();
      op_val = 2'b01; op_data[2*OW-1:OW] = 32'hDEADBEEF;
      exp_gnt_q.push_back(0);
      exp_res_q.push_back({1'b0, 18'h3FFFF, 18'h3FFFF});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_m_op_val", m_op_val, 1);
         chk("t3_m_op_data", m_op_data, 32'h05000007);
         chk("t3_op_rdy_stall", op_rdy, 0);
      end
      step();
      m_op_rdy = 1'b1;
      wait_grants(g + 2);
      step();
      op_val = 2'b00;
      drain();

      // Requester not ready in RET; other requester must wait
      step();
      res_rdy = 2'b00; op_data = {32'h00010001, 32'h02020202}; op_val = 2'b01;
      g = n_grant;
      exp_gnt_q.push_back(0);
      exp_res_q.push_back({1'b0, 18'h00000, 18'h00008});
      wait_grants(g + 1);
      step();
      op_val = 2'b10;
      exp_gnt_q.push_back(1);
      exp_res_q.push_back({1'b1, 18'h3FFFF, 18'h00000});
      wait_res(2'b01, "t4_ret");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_res_val", res_val, 2'b01);
         chk("t4_res_data0", res_data[RW-1:0], {18'h00000, 18'h00008});
         chk("t4_res_data1_held", res_data[2*RW-1:RW], {18'h00000, 18'h00023});
         chk("t4_op_rdy_stall", op_rdy, 0);
      end
      step();
      res_rdy = 2'b11;
      wait_grants(g + 2);
      step();
      op_val = 2'b00;
      drain();

      // Software reset while waiting on the multiplier; late result ignored
      step();
      mul_lat = 3; mul_hold = 4;
      op_data = {32'h0, 32'h01000100}; op_val = 2'b01;
      exp_gnt_q.push_back(0);
      @(negedge clk);
      chk("t5_op_rdy", op_rdy, 2'b01);
      step();
      op_val = 2'b00;
      @(negedge clk);
      chk("t5_m_op_val", m_op_val, 1);
      @(negedge clk);
      chk("t5_m_res_rdy", m_res_rdy, 1);
      step();
      sw_rst = 1'b1;
      step();
      sw_rst = 1'b0;
      @(negedge clk);
      chk("t5_m_op_val_rst", m_op_val, 0);
      chk("t5_m_res_rdy_rst", m_res_rdy, 0);
      chk("t5_res_val_rst", res_val, 0);
      chk("t5_res_data_rst", res_data, 0);
      chk("t5_op_rdy_rst", op_rdy, 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t5_late_m_res_rdy", m_res_rdy, 0);
         chk("t5_late_res_val", res_val, 0);
      end
      step();
      mul_lat = 1; mul_hold = 20;

      // Hard reset during RET, then both requesters: req0 first
      step();
      res_rdy = 2'b00; op_data = {32'h0, 32'h00010100}; op_val = 2'b01;
      g = n_grant;
      exp_gnt_q.push_back(0);
      wait_grants(g + 1);
      step();
      op_val = 2'b00;
      wait_res(2'b01, "t6_ret");
      step();
      rst_n = 1'b0;
      step();
      @(negedge clk);
      chk("t6_res_val_rst", res_val, 0);
      chk("t6_res_data_rst", res_data, 0);
      chk("t6_m_op_val_rst", m_op_val, 0);
      step();
      rst_n = 1'b1; res_rdy = 2'b11;
      op_data = {32'h00030003, 32'h03000300}; op_val = 2'b11;
      g = n_grant;
      exp_gnt_q.push_back(0);
      exp_gnt_q.push_back(1);
      exp_res_q.push_back({1'b0, 18'h00009, 18'h00000});
      exp_res_q.push_back({1'b1, 18'h3FFF7, 18'h00000});
      wait_grants(g + 2);
      step();
      op_val = 2'b00;
      drain();

      chk("gnt_q_empty", exp_gnt_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/comp_mult_arb.md
COMP_MULT_ARB -- requirements
Module: comp_mult_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning operand component width passed to the shared complex multiplier.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst_n, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port sw_rst, input, 1, software synchronous reset, active high.
REQ-005 SHALL have ports op_val, input, 2; op_rdy, output, 2; op_data, input, 2*4*DWIDTH, requester operand val-rdy IF, {x1,y1,x2,y2} per requester, requester i at slice i.
REQ-006 SHALL have ports res_val, output, 2; res_rdy, input, 2; res_data, output, 2*4*(DWIDTH+1), per-requester result val-rdy IF, {xr,yr} per requester.
REQ-007 SHALL have ports m_op_val, output, 1; m_op_rdy, input, 1; m_op_data, output, 4*DWIDTH, operand IF toward the shared complex multiplier.
REQ-008 SHALL have ports m_res_val, input, 1; m_res_rdy, output, 1; m_res_data, input, 4*(DWIDTH+1), result IF from the shared complex multiplier.

Function
REQ-009 SHALL share one multiplier between 2 requesters with at most one transaction outstanding.
REQ-010 SHALL implement FSM states IDLE, SEND, WAIT, RET.
REQ-011 In IDLE, grant = requester with op_val set; both set -> requester indicated by priority pointer ptr.
REQ-012 op_rdy[i] SHALL be 1 only in IDLE and only for the granted requester, combinational on op_val (only op_val->op_rdy path allowed).
REQ-013 On op_val[g] & op_rdy[g]: capture op_data slice g and id=g into registers, set ptr = ~g, go SEND next cycle.
REQ-014 In SEND, m_op_val=1 and m_op_data = captured operand, both stable until m_op_rdy; on m_op_val & m_op_rdy go WAIT.
REQ-015 In WAIT, m_res_rdy=1; on m_res_val capture m_res_data, go RET; m_res_rdy=0 in all other states.
REQ-016 In RET, res_val[id]=1, other res_val bit 0; res_data slice id = captured result; on res_rdy[id] go IDLE.
REQ-017 res_data slices SHALL hold their last delivered result until overwritten; non-delivering slice unchanged.
REQ-018 Minimum latency acceptance -> res_val: 3 cycles with m_op_rdy and m_res_val already high and the multiplier responding the cycle after its operand handshake.
REQ-019 The next grant SHALL NOT occur before the cycle after the RET handshake (no overlap).
REQ-020 Request arriving while not IDLE SHALL stall (op_rdy=0), data untouched; requester holds op_val.
REQ-021 Two consecutive back-to-back requests from both requesters SHALL alternate 0,1,0,1 (round-robin, no starvation).
REQ-022 Result arithmetic SHALL be passed through unchanged; the block performs no computation on data.

Reset
REQ-023 On rst_n=0 at clk edge: state IDLE, ptr=0, id=0, operand/result registers 0, m_op_val=0, m_res_rdy=0, res_val=0, res_data=0.
REQ-024 sw_rst=1 SHALL have the same effect as rst_n=0, in any state, including mid-SEND/WAIT; a result returning after reset is ignored (m_res_rdy=0 in IDLE).
REQ-025 rst_n SHALL take priority over sw_rst, sw_rst over all functional updates.

Verification
REQ-026 Req0 only, op {x1=3,y1=2,x2=1,y2=4}, multiplier returning -5+14j -> m_op_data=0x03020104, res_val[0] asserted, res_data slice0 = {18'h3FFFB,18'h0000E}, res_val[1]=0.
REQ-027 Both op_val high from reset, ops held -> grants req0 then req1 then req0; no two consecutive grants to same requester.
REQ-028 m_op_rdy held 0 for 5 cycles in SEND -> m_op_val and m_op_data stable all 5 cycles; op_rdy=0 for both.
REQ-029 res_rdy[id] held 0 for 4 cycles in RET -> res_val and res_data stable; new op_val on other requester not accepted until after RET handshake.
REQ-030 sw_rst pulse in WAIT -> next cycle IDLE, all outputs at reset values; late m_res_val not captured, no res_val.
REQ-031 rst_n=0 during RET -> res_val clears next edge, ptr=0; with both op_val high after release, req0 granted first.
